// File: rtl/logic_unit_pkg.sv
// Shared opcode encodings, widths and FSM state type for the arbitrated logic unit.
package logic_unit_pkg;

    localparam int OP_W      = 3;
    localparam int DEFAULT_W = 8;

    typedef enum logic [OP_W-1:0] {
        OP_AND     = 3'd0,
        OP_OR      = 3'd1,
        OP_NOT     = 3'd2,
        OP_NAND    = 3'd3,
        OP_NOR     = 3'd4,
        OP_XOR     = 3'd5,
        OP_XNOR    = 3'd6,
        OP_ILLEGAL = 3'd7
    } op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/logic_unit.sv
// Purely combinational bitwise logic unit; opcode 7 yields zero data with err set.
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic [OP_W-1:0] op,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    output logic [W-1:0]    data,
    output logic            err
);

    always_comb begin
        data = '0;
        err  = 1'b0;
        case (op)
            OP_AND:  data = a & b;
            OP_OR:   data = a | b;
            OP_NOT:  data = ~a;
            OP_NAND: data = ~(a & b);
            OP_NOR:  data = ~(a | b);
            OP_XOR:  data = a ^ b;
            OP_XNOR: data = ~(a ^ b);
            default: err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter feeding one shared logic unit into a single-entry result register.
module logic_unit_arbiter
    import logic_unit_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = DEFAULT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [OP_W*NREQ-1:0]     req_op,
    input  logic [W*NREQ-1:0]        req_a,
    input  logic [W*NREQ-1:0]        req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [W-1:0]             res_data,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic                     res_err,
    output logic [15:0]              op_count
);

    localparam int IDW = $clog2(NREQ);

    state_e           r_state;
    logic [W-1:0]     r_data;
    logic [IDW-1:0]   r_id;
    logic             r_err;
    logic [15:0]      r_count;
    logic [IDW-1:0]   r_last_grant;

    logic             w_slot_free;
    logic             w_found;
    logic [IDW-1:0]   w_sel;
    logic [NREQ-1:0]  w_grant;
    logic             w_accept;
    logic [OP_W-1:0]  w_op;
    logic [W-1:0]     w_a;
    logic [W-1:0]     w_b;
    logic [W-1:0]     w_lu_data;
    logic             w_lu_err;

    // Reset gating keeps req_ready low while rst_n is held, even though the FSM reads EMPTY.
    assign w_slot_free = rst_n && ((r_state == ST_EMPTY) || res_ready);

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_grant = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req_valid[(int'(r_last_grant) + k) % NREQ]) begin
                w_found = 1'b1;
                w_sel   = IDW'((int'(r_last_grant) + k) % NREQ);
            end
        end
        if (w_slot_free && w_found) begin
            w_grant[w_sel] = 1'b1;
        end
    end

    assign w_accept = |w_grant;
    assign w_op     = req_op[int'(w_sel)*OP_W +: OP_W];
    assign w_a      = req_a[int'(w_sel)*W +: W];
    assign w_b      = req_b[int'(w_sel)*W +: W];

    logic_unit #(.W(W)) u_logic_unit (
        .op   (w_op),
        .a    (w_a),
        .b    (w_b),
        .data (w_lu_data),
        .err  (w_lu_err)
    );

    // An accept always wins over a drain, which gives back-to-back results with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_EMPTY;
            r_data       <= '0;
            r_id         <= '0;
            r_err        <= 1'b0;
            r_count      <= '0;
            r_last_grant <= IDW'(NREQ - 1);
        end else if (w_accept) begin
            r_state      <= ST_FULL;
            r_data       <= w_lu_data;
            r_id         <= w_sel;
            r_err        <= w_lu_err;
            r_last_grant <= w_sel;
            if (r_count != 16'hFFFF) begin
                r_count <= r_count + 16'd1;
            end
        end else if ((r_state == ST_FULL) && res_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign req_ready = w_grant;
    assign res_valid = (r_state == ST_FULL);
    assign res_data  = r_data;
    assign res_id    = r_id;
    assign res_err   = r_err;
    assign op_count  = r_count;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Randomised bench for logic_unit_arbiter: behavioural model compared every cycle plus literal scenarios.
module tb_logic_unit_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_op = '0;
    logic [W*NREQ-1:0] req_a = '0;
    logic [W*NREQ-1:0] req_b = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [W-1:0]      res_data;
    logic [1:0]        res_id;
    logic              res_err;
    logic [15:0]       op_count;

    int errors = 0;
    int checks = 0;
    bit cmpEn  = 1'b0;

    // Model state: what the result slot should hold, plus arbitration pointer and count.
    bit     mValid = 1'b0;
    int     mData  = 0;
    int     mId    = 0;
    bit     mErr   = 1'b0;
    int     mCount = 0;
    int     mLast  = NREQ - 1;

    logic [7:0] heldData;

    logic_unit_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_err   (res_err),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    function automatic int refOp(input int op, input int a, input int b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return (~a) & 8'hFF;
            3: return (~(a & b)) & 8'hFF;
            4: return (~(a | b)) & 8'hFF;
            5: return a ^ b;
            6: return (~(a ^ b)) & 8'hFF;
            default: return 0;
        endcase
    endfunction

    // Which requester must be granted right now, or -1 for none.
    function automatic int expGrant();
        if (!rst_n) return -1;
        if (mValid && !res_ready) return -1;
        for (int k = 1; k <= NREQ; k++) begin
            if (req_valid[(mLast + k) % NREQ]) return (mLast + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g;
        if (!rst_n) begin
            mValid <= 1'b0;
            mData  <= 0;
            mId    <= 0;
            mErr   <= 1'b0;
            mCount <= 0;
            mLast  <= NREQ - 1;
        end else begin
            g = expGrant();
            if (g >= 0) begin
                mValid <= 1'b1;
                mData  <= refOp(int'(req_op[g*3 +: 3]), int'(req_a[g*W +: W]), int'(req_b[g*W +: W]));
                mErr   <= (req_op[g*3 +: 3] == 3'd7);
                mId    <= g;
                mLast  <= g;
                if (mCount < 16'hFFFF) mCount <= mCount + 1;
            end else if (mValid && res_ready) begin
                mValid <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareModel();
        int g;
        logic [31:0] expReady;
        g = expGrant();
        expReady = (g < 0) ? 32'd0 : (32'd1 << g);
        checkOutput("model req_ready", 32'(req_ready), expReady);
        checkOutput("model res_valid", 32'(res_valid), 32'(mValid));
        if (mValid) begin
            checkOutput("model res_data", 32'(res_data), 32'(mData));
            checkOutput("model res_id", 32'(res_id), 32'(mId));
            checkOutput("model res_err", 32'(res_err), 32'(mErr));
        end
        checkOutput("model op_count", 32'(op_count), 32'(mCount));
    endtask

    always @(negedge clk) begin
        if (cmpEn) compareModel();
    end

    task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [3*NREQ-1:0] op,
                                 input logic [W*NREQ-1:0] a, input logic [W*NREQ-1:0] b,
                                 input logic rr);
        @(posedge clk);
        #1;
        req_valid = v;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        res_ready = rr;
    endtask

    initial begin
        int order[5];
        logic [7:0] expTab[8];
        order  = '{0, 1, 2, 3, 0};
        expTab = '{8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00};

        // Reset values, with requests pending to prove req_ready stays low.
        req_valid = 4'b1111;
        repeat (3) @(negedge clk);
        checkOutput("reset req_ready", 32'(req_ready), 32'h0);
        checkOutput("reset res_valid", 32'(res_valid), 32'h0);
        checkOutput("reset res_data", 32'(res_data), 32'h0);
        checkOutput("reset res_id", 32'(res_id), 32'h0);
        checkOutput("reset res_err", 32'(res_err), 32'h0);
        checkOutput("reset op_count", 32'(op_count), 32'h0);
        req_valid = '0;
        #1 rst_n = 1'b1;
        cmpEn = 1'b1;

        // Single AND transaction on requester 0.
        applyStimulus(4'b0001, 12'h000, 32'h000000F0, 32'h0000003C, 1'b0);
        @(negedge clk);
        checkOutput("first req_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        checkOutput("first res_valid", 32'(res_valid), 32'h1);
        checkOutput("first res_data", 32'(res_data), 32'h30);
        checkOutput("first res_id", 32'(res_id), 32'h0);
        checkOutput("first res_err", 32'(res_err), 32'h0);
        checkOutput("first op_count", 32'(op_count), 32'h1);
        applyStimulus(4'b0000, 12'h000, 32'h0, 32'h0, 1'b1);

        // Fresh reset, then all requesters streaming: grants 0,1,2,3,0 back to back.
        @(negedge clk);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        applyStimulus(4'b1111, 12'o5310, 32'h44332211, 32'h0F0F0F0F, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rr grant order", 32'(req_ready), 32'd1 << order[i]);
            if (i > 0) begin
                checkOutput("rr res_valid", 32'(res_valid), 32'h1);
                checkOutput("rr res_id", 32'(res_id), 32'(order[i-1]));
            end
        end

        // Backpressure: slot held for three cycles, then grant resumes in the release cycle.
        applyStimulus(4'b1111, 12'o5310, 32'h44332211, 32'h0F0F0F0F, 1'b0);
        @(negedge clk);
        heldData = res_data;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("stall req_ready", 32'(req_ready), 32'h0);
            checkOutput("stall res_id", 32'(res_id), 32'h0);
            checkOutput("stall res_data", 32'(res_data), 32'(heldData));
        end
        applyStimulus(4'b1111, 12'o5310, 32'h44332211, 32'h0F0F0F0F, 1'b1);
        @(negedge clk);
        checkOutput("release req_ready", 32'(req_ready), 32'h2);

        // Every opcode on a=A5, b=0F.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b0001, 12'(k), 32'h000000A5, 32'h0000000F, 1'b1);
            @(negedge clk);
            @(negedge clk);
            checkOutput("opcode res_data", 32'(res_data), 32'(expTab[k]));
            checkOutput("opcode res_err", 32'(res_err), (k == 7) ? 32'h1 : 32'h0);
        end

        // Asynchronous reset while a result is held.
        applyStimulus(4'b1111, 12'o1234, 32'h11223344, 32'h55667788, 1'b0);
        @(negedge clk);
        checkOutput("pre-reset res_valid", 32'(res_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async res_valid", 32'(res_valid), 32'h0);
        checkOutput("async req_ready", 32'(req_ready), 32'h0);
        checkOutput("async op_count", 32'(op_count), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("post-reset priority", 32'(req_ready), 32'h1);

        // Random traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            applyStimulus(4'($urandom), 12'($urandom), $urandom, $urandom,
                          ($urandom_range(0, 3) != 0));
        end

        // Saturation of the accept counter.
        applyStimulus(4'b0001, 12'h005, 32'h000000A5, 32'h0000000F, 1'b1);
        repeat (65540) @(negedge clk);
        checkOutput("saturated op_count", 32'(op_count), 32'hFFFF);
        repeat (4) @(negedge clk);
        checkOutput("held op_count", 32'(op_count), 32'hFFFF);

        cmpEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter W, default 8, operand/result width in bits.
REQ-003 clk  input  1  single clock; all state rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NREQ  per-requester request valid.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit set per cycle.
REQ-007 req_op  input  3*NREQ  opcode of requester i in bits [3i+2:3i].
REQ-008 req_a, req_b  input  W*NREQ  operands of requester i in bits [Wi+W-1:Wi].
REQ-009 res_valid  output  1  result register holds a result.
REQ-010 res_ready  input  1  consumer accepts result.
REQ-011 res_data  output  W  result.
REQ-012 res_id  output  clog2(NREQ)  index of the requester that produced res_data.
REQ-013 res_err  output  1  result came from an illegal opcode.
REQ-014 op_count  output  16  count of accepted requests, saturating.

Function
REQ-015 Opcodes: 0 AND, 1 OR, 2 NOT (a only, b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 illegal; all operations bitwise over W bits.
REQ-016 Illegal opcode: request accepted normally, res_data=0, res_err=1; legal opcodes give res_err=0.
REQ-017 Two-state FSM on the result register: EMPTY (res_valid=0) and FULL (res_valid=1).
REQ-018 Slot is free when state is EMPTY, or when FULL and res_ready=1 in the same cycle (drain-and-refill).
REQ-019 When the slot is free, the arbiter asserts req_ready for exactly one requester with req_valid=1, chosen round-robin, searching from index last_grant+1 upward with wrap from NREQ-1 to 0.
REQ-020 req_ready is combinational from req_valid, FSM state, res_ready and last_grant; no req_ready bit is set when no request is valid or the slot is not free.
REQ-021 Accept (req_valid[i] & req_ready[i]) loads res_data, res_id=i and res_err on the next rising edge; latency is exactly 1 cycle; the FSM moves to or stays in FULL.
REQ-022 FULL with res_ready=1 and no accept moves to EMPTY; FULL with res_ready=0 holds res_data/res_id/res_err stable.
REQ-023 last_grant updates to i only on an accept; otherwise it holds.
REQ-024 op_count increments by 1 on each accept and saturates at 0xFFFF.
REQ-025 Requesters may drop req_valid without an accept; the arbiter keeps no per-requester state.

Reset
REQ-026 While rst_n=0: FSM EMPTY, res_valid=0, res_data=0, res_id=0, res_err=0, op_count=0, last_grant=NREQ-1 (so requester 0 has first priority), req_ready=0.
REQ-027 Reset asserted mid-transaction discards any held result with no output handshake; operation resumes on the first rising edge after rst_n deasserts.

Structure
REQ-028 Package logic_unit_pkg holds the opcode constants (OP_AND..OP_XNOR, OP_ILLEGAL), the opcode width 3, and the default W.
REQ-029 Sub-module logic_unit: purely combinational, inputs op/a/b, outputs data/err; instantiated once and fed from the granted requester's mux.
REQ-030 Round-robin selection, FSM, result register and counter live in logic_unit_arbiter.

Verification
REQ-031 Reset, then req_valid=0001, op=0, a=0xF0, b=0x3C -> req_ready=0001 in the same cycle; the next cycle gives res_valid=1, res_data=0x30, res_id=0, res_err=0, op_count=1.
REQ-032 All four requesters valid continuously with res_ready=1 -> grants in the order 0,1,2,3,0 on consecutive cycles, one result per cycle, no bubbles.
REQ-033 Result FULL, res_ready=0 for 3 cycles with requesters valid -> req_ready=0000 and outputs stable; on res_ready=1 the next grant happens in that same cycle.
REQ-034 Each opcode 0..7 with a=0xA5, b=0x0F -> results 05, AF, 5A, FA, 50, AA, 55, 00 (opcode 7 with res_err=1).
REQ-035 Preload op_count near saturation by 65540 accepts -> op_count holds at 0xFFFF.
REQ-036 Assert rst_n=0 while FULL and res_ready=0 -> res_valid drops immediately (asynchronously); after release requester 0 has priority.
